// File: rtl/large_int_accum_ctrl.sv
// large_int_accum_ctrl: sums a counted stream of IEEE-754 singles exactly
// in a wide two's-complement fixed-point accumulator and hands the total
// out over a valid/ready result port.
// Optional feature macro: FLOAT_ACCUM_NANINF_DETECT_EN adds the sticky err_o
// flag that records any accepted NaN or Inf input.

// FloatToLargeInteger: exact conversion of a float32 into a signed
// fixed-point integer whose LSB weighs 2^-149, the smallest denormal step.
// The largest finite magnitude needs 277 bits, so 279 bits leave a sign bit
// and one bit of headroom. NaN and Inf have no finite value; they convert
// to zero so that they never disturb a running sum.
module FloatToLargeInteger #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 279
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);

    logic             w_sign;
    logic [7:0]       w_exp;
    logic [23:0]      w_mant;
    logic [7:0]       w_shift;
    logic [OUT_W-1:0] w_mag;

    assign w_sign  = in_i[31];
    assign w_exp   = in_i[30:23];
    assign w_mant  = {(w_exp != 8'd0), in_i[22:0]};
    assign w_shift = (w_exp == 8'd0) ? 8'd0 : (w_exp - 8'd1);
    assign w_mag   = {{(OUT_W-24){1'b0}}, w_mant} << w_shift;

    // Apply the sign; non-finite encodings produce a zero contribution.
    always_comb begin
        out_o = '0;
        if (w_exp != 8'hFF) begin
            out_o = w_sign ? (~w_mag + 1'b1) : w_mag;
        end
    end

endmodule

module large_int_accum_ctrl #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 279,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             in_ready_o,
    output logic             res_valid_o,
    output logic [OUT_W-1:0] res_data_o,
    input  logic             res_ready_i
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
    ,
    output logic             err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_remaining;
    logic [OUT_W-1:0] r_convQ;
    logic             r_convV;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_conv;
    logic             w_xfer;
    logic             w_startAccepted;

    FloatToLargeInteger #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_conv (
        .in_i  (in_data_i),
        .out_o (w_conv)
    );

    assign in_ready_o      = (r_state == LOAD);
    assign busy_o          = (r_state != IDLE);
    assign res_valid_o     = (r_state == DONE);
    assign res_data_o      = r_acc;
    assign w_xfer          = in_valid_i && in_ready_o;
    assign w_startAccepted = (r_state == IDLE) && start_i;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: the last transfer leaves one drain cycle so the final
    // converted value lands in the accumulator before the result is offered.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_nextState = (len_i != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (w_xfer && (r_remaining == CNT_W'(1))) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_nextState = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: conversion stage, element countdown and wrapping accumulator.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_convQ     <= '0;
            r_convV     <= 1'b0;
            r_acc       <= '0;
            r_remaining <= '0;
        end else begin
            r_convV <= w_xfer;
            if (w_xfer) begin
                r_convQ     <= w_conv;
                r_remaining <= r_remaining - CNT_W'(1);
            end else if (w_startAccepted) begin
                r_remaining <= len_i;
            end
            if (w_startAccepted) begin
                r_acc <= '0;
            end else if (r_convV) begin
                r_acc <= r_acc + r_convQ;
            end
        end
    end

`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
    logic r_err;

    assign err_o = r_err;

    // Sticky non-finite flag, cleared by reset or by the next accepted job.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_startAccepted) begin
            r_err <= 1'b0;
        end else if (w_xfer && (in_data_i[30:23] == 8'hFF)) begin
            r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_large_int_accum_ctrl.sv
// Self-checking bench for large_int_accum_ctrl: directed jobs plus random
// jobs, with expected sums queued by the stimulus side and compared by an
// independent result monitor. Define FLOAT_ACCUM_NANINF_DETECT_EN to also
// exercise the err_o flag.
module tb_large_int_accum_ctrl;

    localparam int IN_W  = 32;
    localparam int OUT_W = 279;
    localparam int CNT_W = 16;

    typedef logic [OUT_W-1:0] big_t;

    logic             clk = 1'b0;
    logic             rst_n_i;
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             busy_o;
    logic             in_valid_i;
    logic [IN_W-1:0]  in_data_i;
    logic             in_ready_o;
    logic             res_valid_o;
    logic [OUT_W-1:0] res_data_o;
    logic             res_ready_i;
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
    logic             err_o;
    logic             errExp;
`endif

    big_t        expQ[$];
    logic [31:0] jobVals[$];
    bit          useOverride;
    big_t        overrideExp;
    int          testsRun    = 0;
    int          testsFailed = 0;
    int          readyMode   = 0;
    bit          monHeld     = 1'b0;
    big_t        monData;

    large_int_accum_ctrl #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_ready_i (res_ready_i)
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;

    // Exact value of a float32 scaled by 2^149, from the IEEE definition:
    // normal = (2^23 + frac) * 2^(exp-150), denormal = frac * 2^-149.
    // Non-finite inputs are defined to contribute nothing.
    function automatic big_t floatValue(input logic [31:0] b);
        big_t mag;
        int   e;
        e = int'(b[30:23]);
        if (e == 255) return '0;
        mag = big_t'(b[22:0]);
        if (e != 0) begin
            mag = mag + big_t'(32'h0080_0000);
            for (int k = 0; k < e - 1; k++) mag = mag * 2;
        end
        return b[31] ? (big_t'(0) - mag) : mag;
    endfunction

    function automatic logic [31:0] randFloat();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 9))
            0: f = 32'h0000_0000;
            1: f = 32'h8000_0000;
            2: f[30:23] = 8'd0;
            3: f[30:23] = 8'(($urandom_range(1, 254)));
            4: f[30:23] = 8'hFF;
            default: f[30:23] = 8'(($urandom_range(120, 135)));
        endcase
        return f;
    endfunction

    task automatic checkOutput(input string name, input big_t actual, input big_t expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, wanted %b", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    task automatic waitIdle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failNow("idle wait");
    endtask

    task automatic startJob(input int len);
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = CNT_W'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        len_i   = CNT_W'($urandom);
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
        errExp = 1'b0;
        checkBit("err cleared by start", err_o, 1'b0);
`endif
        if (len > 0) begin
            checkBit("busy after start", busy_o, 1'b1);
            checkBit("ready after start", in_ready_o, 1'b1);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] b, output bit ok);
        in_valid_i = 1'b1;
        in_data_i  = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("input ready wait");
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
    endtask

    // Runs one job from jobVals; returns one cycle after the result appears.
    task automatic runJob(input bit midStart, input int gapMax);
        big_t sum;
        bit   ok;
        int   n;
        n   = jobVals.size();
        sum = '0;
        startJob(n);
        if (n == 0) begin
            expQ.push_back('0);
            checkBit("empty job valid", res_valid_o, 1'b1);
            checkOutput("empty job data", res_data_o, '0);
        end
        for (int i = 0; i < n; i++) begin
            sum = sum + floatValue(jobVals[i]);
            if (i == n - 1) expQ.push_back(useOverride ? overrideExp : sum);
            applyStimulus(jobVals[i], ok);
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
            if (jobVals[i][30:23] == 8'hFF) errExp = 1'b1;
            checkBit("err after transfer", err_o, errExp);
`endif
            if (midStart && i == 0) begin
                start_i = 1'b1;
                len_i   = CNT_W'(7);
                @(posedge clk); #1;
                start_i = 1'b0;
            end
            if (i < n - 1) begin
                repeat ($urandom_range(0, gapMax)) begin
                    @(negedge clk);
                    checkBit("ready in gap", in_ready_o, 1'b1);
                    @(posedge clk); #1;
                end
            end else begin
                checkBit("drain no valid", res_valid_o, 1'b0);
                checkBit("drain no ready", in_ready_o, 1'b0);
                @(posedge clk); #1;
                checkBit("result latency", res_valid_o, 1'b1);
            end
        end
        useOverride = 1'b0;
    endtask

    // Result-side handshake driver; the mode is chosen by the stimulus.
    initial begin
        res_ready_i = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (readyMode)
                0: res_ready_i = ($urandom_range(0, 2) != 0);
                1: res_ready_i = 1'b0;
                default: res_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: checks held results stay stable and scores each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n_i) begin
                monHeld = 1'b0;
            end else begin
                if (monHeld) begin
                    checkBit("held valid", res_valid_o, 1'b1);
                    checkOutput("held data", res_data_o, monData);
                end
                if (res_valid_o && res_ready_i) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected result: got %h, wanted none", res_data_o);
                    end else begin
                        checkOutput("result", res_data_o, expQ.pop_front());
                    end
                    monHeld = 1'b0;
                end else if (res_valid_o) begin
                    monHeld = 1'b1;
                    monData = res_data_o;
                end else begin
                    monHeld = 1'b0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        bit ok;
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        useOverride = 1'b0;
        overrideExp = '0;
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
        errExp = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkBit("reset busy", busy_o, 1'b0);
        checkBit("reset in_ready", in_ready_o, 1'b0);
        checkBit("reset res_valid", res_valid_o, 1'b0);
        checkOutput("reset res_data", res_data_o, '0);
`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
        checkBit("reset err", err_o, 1'b0);
`endif
        rst_n_i = 1'b1;

        // 1+2+3+4 back-to-back must equal the conversion of 10.0.
        readyMode   = 2;
        jobVals     = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        useOverride = 1'b1;
        overrideExp = floatValue(32'h4120_0000);
        runJob(1'b0, 0);
        waitIdle();

        // 1.5 then -1.5 with a three-cycle gap cancels exactly.
        jobVals = '{32'h3FC0_0000};
        startJob(2);
        applyStimulus(32'h3FC0_0000, ok);
        repeat (3) begin
            @(negedge clk);
            checkBit("ready across gap", in_ready_o, 1'b1);
            @(posedge clk); #1;
        end
        expQ.push_back('0);
        applyStimulus(32'hBFC0_0000, ok);
        @(posedge clk); #1;
        checkBit("gap job valid", res_valid_o, 1'b1);
        waitIdle();

        // Empty job: result held while the consumer stalls for five cycles.
        readyMode = 1;
        jobVals.delete();
        runJob(1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        checkBit("stalled still busy", busy_o, 1'b1);
        readyMode = 2;
        waitIdle();

        // Reset in the middle of a job aborts it with no result.
        startJob(4);
        applyStimulus(32'h3F80_0000, ok);
        applyStimulus(32'h4000_0000, ok);
        rst_n_i = 1'b0;
        @(posedge clk); #1;
        checkBit("abort busy", busy_o, 1'b0);
        checkBit("abort in_ready", in_ready_o, 1'b0);
        checkBit("abort res_valid", res_valid_o, 1'b0);
        checkOutput("abort res_data", res_data_o, '0);
        rst_n_i = 1'b1;
        jobVals = '{32'h4000_0000};
        useOverride = 1'b1;
        overrideExp = floatValue(32'h4000_0000);
        runJob(1'b0, 0);
        waitIdle();

        // A start pulse during LOAD must not change the element count.
        jobVals = '{32'h4040_0000, 32'hC000_0000, 32'h3E80_0000};
        runJob(1'b1, 1);
        waitIdle();

`ifdef FLOAT_ACCUM_NANINF_DETECT_EN
        // Infinity raises the sticky flag without disturbing the sum.
        readyMode = 1;
        jobVals   = '{32'h7F80_0000, 32'h3F80_0000};
        runJob(1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkBit("err held in done", err_o, 1'b1);
        readyMode = 2;
        waitIdle();
        checkBit("err held in idle", err_o, 1'b1);
        jobVals = '{32'h3F80_0000};
        runJob(1'b0, 0);
        waitIdle();
`endif

        // Random jobs with stray valids in IDLE and a random consumer.
        readyMode = 0;
        for (int j = 0; j < 25; j++) begin
            waitIdle();
            @(posedge clk); #1;
            in_valid_i = 1'b1;
            in_data_i  = randFloat();
            repeat (2) begin
                @(negedge clk);
                checkBit("idle ignores input", in_ready_o, 1'b0);
                @(posedge clk); #1;
            end
            in_valid_i = 1'b0;
            jobVals.delete();
            repeat ($urandom_range(0, 6)) jobVals.push_back(randFloat());
            runJob(1'b0, 2);
        end
        readyMode = 2;
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", big_t'(expQ.size()), '0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
